// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the datapath/memory side.
// master = controller, slave = datapath and memory.
interface multicycle_ctrl_if;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       alusrca_o;
  logic       memtoreg_o;
  logic       iord_o;
  logic       regwrite_o;
  logic       regdst_o;
  logic       irwrite_o;
  logic       pcen_o;
  logic       bne_o;
  logic       j_o;
  logic       jr_o;
  logic [1:0] pcsource_o;
  logic [2:0] alusrcb_o;
  logic [2:0] alucont_o;
  logic       memread_o;
  logic       memwrite_o;
  logic [3:0] state_o;
  logic       retire_o;
  logic       err_o;

  modport master (
    input  op_i, funct_i, zero_i, mem_ready_i,
    output alusrca_o, memtoreg_o, iord_o, regwrite_o, regdst_o, irwrite_o, pcen_o,
    output bne_o, j_o, jr_o, pcsource_o, alusrcb_o, alucont_o, memread_o, memwrite_o,
    output state_o, retire_o, err_o
  );

  modport slave (
    output op_i, funct_i, zero_i, mem_ready_i,
    input  alusrca_o, memtoreg_o, iord_o, regwrite_o, regdst_o, irwrite_o, pcen_o,
    input  bne_o, j_o, jr_o, pcsource_o, alusrcb_o, alucont_o, memread_o, memwrite_o,
    input  state_o, retire_o, err_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences one instruction FETCH..writeback,
// handshakes memory via mem_ready_i with a bounded wait, and flags illegal ops/timeouts.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_if.master  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StJr      = 4'd12
  } state_e;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            wait_st, tmo, op_ok, funct_ok;
  logic [2:0]      rt_alu;

  assign op_ok = bus.op_i inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                  6'b001000, 6'b000010};
  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign tmo = wait_st && !bus.mem_ready_i && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    funct_ok = 1'b1;
    rt_alu   = 3'b000;
    case (bus.funct_i)
      6'b100000: rt_alu = AluAdd;
      6'b100010: rt_alu = AluSub;
      6'b100100: rt_alu = AluAnd;
      6'b100101: rt_alu = AluOr;
      6'b101010: rt_alu = AluSlt;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    err_q   <= err_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      StFetch:   if (bus.mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (bus.op_i)
          6'b100011, 6'b101011: state_d = StMemAdr;
          6'b000000: state_d = (bus.funct_i == 6'b001000) ? StJr : StRtypeEx;
          6'b000100, 6'b000101: state_d = StBranch;
          6'b001000: state_d = StAddiEx;
          6'b000010: state_d = StJump;
          default: begin
            state_d = StFetch;
            err_d   = 1'b1;
          end
        endcase
      end
      StMemAdr:  state_d = (bus.op_i == 6'b100011) ? StMemRd : StMemWr;
      StMemRd:   if (bus.mem_ready_i) state_d = StMemWb;
      StMemWr:   if (bus.mem_ready_i) state_d = StFetch;
      StRtypeEx: begin
        if (funct_ok) begin
          state_d = StRtypeWb;
        end else begin
          state_d = StFetch;
          err_d   = 1'b1;
        end
      end
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
    if (tmo) begin
      state_d = StFetch;
      err_d   = 1'b1;
    end
    if (rst) begin
      state_d = StFetch;
      err_d   = 1'b0;
    end
  end

  // Counter restarts whenever the state is (re)entered, including a timed-out refetch.
  always_comb begin
    if (rst || tmo || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (wait_st && !bus.mem_ready_i) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    bus.alusrca_o  = 1'b0;
    bus.memtoreg_o = 1'b0;
    bus.iord_o     = 1'b0;
    bus.regwrite_o = 1'b0;
    bus.regdst_o   = 1'b0;
    bus.irwrite_o  = 1'b0;
    bus.pcen_o     = 1'b0;
    bus.bne_o      = 1'b0;
    bus.j_o        = 1'b0;
    bus.jr_o       = 1'b0;
    bus.pcsource_o = 2'b00;
    bus.alusrcb_o  = 3'b000;
    bus.alucont_o  = 3'b000;
    bus.memread_o  = 1'b0;
    bus.memwrite_o = 1'b0;
    bus.retire_o   = 1'b0;
    case (state_q)
      StFetch: begin
        bus.memread_o = 1'b1;
        bus.alusrcb_o = 3'b001;
        bus.alucont_o = AluAdd;
        bus.irwrite_o = bus.mem_ready_i;
        bus.pcen_o    = bus.mem_ready_i;
      end
      StDecode: begin
        bus.alusrcb_o = 3'b011;
        bus.alucont_o = AluAdd;
        bus.retire_o  = !op_ok;
      end
      StMemAdr, StAddiEx: begin
        bus.alusrca_o = 1'b1;
        bus.alusrcb_o = 3'b100;
        bus.alucont_o = AluAdd;
      end
      StMemRd: begin
        bus.memread_o = 1'b1;
        bus.iord_o    = 1'b1;
      end
      StMemWb: begin
        bus.memtoreg_o = 1'b1;
        bus.regwrite_o = 1'b1;
        bus.retire_o   = 1'b1;
      end
      StMemWr: begin
        bus.memwrite_o = 1'b1;
        bus.iord_o     = 1'b1;
        bus.retire_o   = bus.mem_ready_i;
      end
      StRtypeEx: begin
        bus.alusrca_o = 1'b1;
        bus.alucont_o = rt_alu;
        bus.retire_o  = !funct_ok;
      end
      StRtypeWb: begin
        bus.regdst_o   = 1'b1;
        bus.regwrite_o = 1'b1;
        bus.retire_o   = 1'b1;
      end
      StBranch: begin
        bus.alusrca_o  = 1'b1;
        bus.alucont_o  = AluSub;
        bus.pcsource_o = 2'b01;
        bus.bne_o      = (bus.op_i == 6'b000101);
        bus.pcen_o     = bus.zero_i ^ (bus.op_i == 6'b000101);
        bus.retire_o   = 1'b1;
      end
      StAddiWb: begin
        bus.regwrite_o = 1'b1;
        bus.retire_o   = 1'b1;
      end
      StJump: begin
        bus.pcsource_o = 2'b10;
        bus.j_o        = 1'b1;
        bus.pcen_o     = 1'b1;
        bus.retire_o   = 1'b1;
      end
      StJr: begin
        bus.alusrca_o = 1'b1;
        bus.alusrcb_o = 3'b101;
        bus.alucont_o = AluAdd;
        bus.jr_o      = 1'b1;
        bus.pcen_o    = 1'b1;
        bus.retire_o  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.pcen_o     = 1'b0;
      bus.irwrite_o  = 1'b0;
      bus.regwrite_o = 1'b0;
      bus.memread_o  = 1'b0;
      bus.memwrite_o = 1'b0;
      bus.retire_o   = 1'b0;
    end
  end

  assign bus.state_o = state_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4): walks each instruction class,
// memory waits, branch conditions, illegal op, memory timeout and mid-instruction reset.
module tb_multicycle_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.op_i = 6'd0;
    bus.funct_i = 6'd0;
    bus.zero_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    tick;
    tick;
    settle;
    chk("rst_memread", 32'(bus.memread_o), 32'd0);
    chk("rst_pcen", 32'(bus.pcen_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    settle;
    chk("post_rst_state", 32'(bus.state_o), 32'd0);
    chk("post_rst_memread", 32'(bus.memread_o), 32'd1);

    // add
    bus.op_i = 6'b000000;
    bus.funct_i = 6'b100000;
    settle;
    chk("add_f_irwrite", 32'(bus.irwrite_o), 32'd1);
    chk("add_f_pcen", 32'(bus.pcen_o), 32'd1);
    chk("add_f_alusrcb", 32'(bus.alusrcb_o), 32'd1);
    tick;
    chk("add_d_state", 32'(bus.state_o), 32'd1);
    chk("add_d_alusrcb", 32'(bus.alusrcb_o), 32'd3);
    chk("add_d_memread", 32'(bus.memread_o), 32'd0);
    tick;
    chk("add_ex_state", 32'(bus.state_o), 32'd6);
    chk("add_ex_alucont", 32'(bus.alucont_o), 32'd2);
    chk("add_ex_regwrite", 32'(bus.regwrite_o), 32'd0);
    chk("add_ex_alusrca", 32'(bus.alusrca_o), 32'd1);
    tick;
    chk("add_wb_state", 32'(bus.state_o), 32'd7);
    chk("add_wb_regwrite", 32'(bus.regwrite_o), 32'd1);
    chk("add_wb_regdst", 32'(bus.regdst_o), 32'd1);
    chk("add_wb_retire", 32'(bus.retire_o), 32'd1);
    tick;
    chk("add_end_state", 32'(bus.state_o), 32'd0);
    chk("add_end_retire", 32'(bus.retire_o), 32'd0);

    // lw with two wait cycles
    bus.op_i = 6'b100011;
    tick;
    tick;
    chk("lw_adr_state", 32'(bus.state_o), 32'd2);
    chk("lw_adr_alusrcb", 32'(bus.alusrcb_o), 32'd4);
    tick;
    bus.mem_ready_i = 1'b0;
    settle;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.mem_ready_i = 1'b1;
        settle;
      end
      chk("lw_rd_state", 32'(bus.state_o), 32'd3);
      chk("lw_rd_memread", 32'(bus.memread_o), 32'd1);
      chk("lw_rd_iord", 32'(bus.iord_o), 32'd1);
      tick;
    end
    chk("lw_wb_state", 32'(bus.state_o), 32'd4);
    chk("lw_wb_memtoreg", 32'(bus.memtoreg_o), 32'd1);
    chk("lw_wb_regwrite", 32'(bus.regwrite_o), 32'd1);
    chk("lw_wb_retire", 32'(bus.retire_o), 32'd1);
    tick;
    chk("lw_end_state", 32'(bus.state_o), 32'd0);

    // beq
    bus.op_i = 6'b000100;
    tick;
    tick;
    bus.zero_i = 1'b1;
    settle;
    chk("beq_state", 32'(bus.state_o), 32'd8);
    chk("beq_z1_pcen", 32'(bus.pcen_o), 32'd1);
    chk("beq_pcsource", 32'(bus.pcsource_o), 32'd1);
    chk("beq_bne", 32'(bus.bne_o), 32'd0);
    chk("beq_alucont", 32'(bus.alucont_o), 32'd6);
    bus.zero_i = 1'b0;
    settle;
    chk("beq_z0_pcen", 32'(bus.pcen_o), 32'd0);
    tick;

    // bne
    bus.op_i = 6'b000101;
    tick;
    tick;
    chk("bne_z0_pcen", 32'(bus.pcen_o), 32'd1);
    chk("bne_bne", 32'(bus.bne_o), 32'd1);
    bus.zero_i = 1'b1;
    settle;
    chk("bne_z1_pcen", 32'(bus.pcen_o), 32'd0);
    bus.zero_i = 1'b0;
    tick;

    // jr
    bus.op_i = 6'b000000;
    bus.funct_i = 6'b001000;
    tick;
    tick;
    chk("jr_state", 32'(bus.state_o), 32'd12);
    chk("jr_alusrcb", 32'(bus.alusrcb_o), 32'd5);
    chk("jr_jr", 32'(bus.jr_o), 32'd1);
    chk("jr_pcen", 32'(bus.pcen_o), 32'd1);
    tick;

    // j
    bus.op_i = 6'b000010;
    tick;
    tick;
    chk("j_state", 32'(bus.state_o), 32'd11);
    chk("j_pcsource", 32'(bus.pcsource_o), 32'd2);
    chk("j_j", 32'(bus.j_o), 32'd1);
    chk("j_pcen", 32'(bus.pcen_o), 32'd1);
    tick;

    // illegal opcode
    bus.op_i = 6'b111111;
    tick;
    chk("ill_d_retire", 32'(bus.retire_o), 32'd1);
    chk("ill_d_err", 32'(bus.err_o), 32'd0);
    tick;
    bus.mem_ready_i = 1'b0;
    settle;
    chk("ill_state", 32'(bus.state_o), 32'd0);
    chk("ill_err", 32'(bus.err_o), 32'd1);
    chk("ill_regwrite", 32'(bus.regwrite_o), 32'd0);
    chk("ill_pcen", 32'(bus.pcen_o), 32'd0);
    rst = 1'b1;
    bus.mem_ready_i = 1'b1;
    settle;
    chk("rstcyc_pcen", 32'(bus.pcen_o), 32'd0);
    chk("rstcyc_irwrite", 32'(bus.irwrite_o), 32'd0);
    tick;
    rst = 1'b0;
    settle;
    chk("ill_rst_err", 32'(bus.err_o), 32'd0);

    // sw with memory stuck low: times out after 4 cycles
    bus.op_i = 6'b101011;
    tick;
    tick;
    tick;
    bus.mem_ready_i = 1'b0;
    settle;
    for (int i = 0; i < 4; i++) begin
      chk("sw_wr_state", 32'(bus.state_o), 32'd5);
      chk("sw_wr_memwrite", 32'(bus.memwrite_o), 32'd1);
      chk("sw_wr_retire", 32'(bus.retire_o), 32'd0);
      tick;
    end
    chk("tmo_state", 32'(bus.state_o), 32'd0);
    chk("tmo_err", 32'(bus.err_o), 32'd1);
    chk("tmo_memwrite", 32'(bus.memwrite_o), 32'd0);
    chk("tmo_irwrite", 32'(bus.irwrite_o), 32'd0);

    // reset during RTYPEEX
    rst = 1'b1;
    bus.mem_ready_i = 1'b1;
    tick;
    rst = 1'b0;
    bus.op_i = 6'b000000;
    bus.funct_i = 6'b100010;
    tick;
    tick;
    chk("rx_state", 32'(bus.state_o), 32'd6);
    chk("rx_alucont", 32'(bus.alucont_o), 32'd6);
    rst = 1'b1;
    settle;
    chk("rx_rst_regwrite", 32'(bus.regwrite_o), 32'd0);
    tick;
    rst = 1'b0;
    settle;
    chk("rx_after_state", 32'(bus.state_o), 32'd0);
    chk("rx_after_regwrite", 32'(bus.regwrite_o), 32'd0);
    chk("rx_after_memread", 32'(bus.memread_o), 32'd1);
    chk("rx_after_err", 32'(bus.err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
